pc_dump_scheduler: RTL and testbench
====================================

PC_DUMP_SCHEDULER -- requirements
Module: pc_dump_scheduler

Interface
REQ-001 Param AXI_ADDR_WIDTH, 64, width of dump address.
REQ-002 Param DUMP_BYTES, 96, bytes written per counter dump (6 beats x 16 B).
REQ-003 Param MAX_PENDING, 4, max queued dump requests.
REQ-004 Param TIMEOUT_CYCLES, 4096, max cycles waiting for pc_done.
REQ-005 clk  in  1  clock; all logic on posedge clk.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 cfg_enable  in  1  accept new dump requests.
REQ-008 cfg_base_addr  in  AXI_ADDR_WIDTH  DDR base of dump ring.
REQ-009 cfg_num_slots  in  16  ring slot count; 0 treated as 1.
REQ-010 dump_req  in  1  one-cycle pulse requesting a counter dump (e.g. end of layer).
REQ-011 err_clear  in  1  pulse clearing sticky error flags.
REQ-012 pc_start  out  1  one-cycle start pulse to the counter dump engine.
REQ-013 pc_addr  out  AXI_ADDR_WIDTH  dump address to the counter dump engine.
REQ-014 pc_done  in  1  one-cycle completion pulse from the dump engine.
REQ-015 pc_clear  out  1  one-cycle pulse zeroing all performance counters.
REQ-016 busy  out  1  high whenever state != IDLE.
REQ-017 pending_cnt  out  3  queued requests not yet started.
REQ-018 dump_count  out  32  completed dumps, wraps at 2^32.
REQ-019 overflow_err, timeout_err  out  1 each  sticky error flags.

Function
REQ-020 FSM states IDLE, START, WAIT_DONE, CLEAR; one-hot or binary encoding left to implementation.
REQ-021 IDLE -> START when pending_cnt > 0; pending_cnt decrements on this transition.
REQ-022 START: pc_start = 1 for exactly one cycle; next state WAIT_DONE unconditionally.
REQ-023 WAIT_DONE: pc_done -> CLEAR; else timeout counter increments, reaching TIMEOUT_CYCLES-1 sets timeout_err and -> IDLE without advancing slot or dump_count.
REQ-024 CLEAR: pc_clear = 1 one cycle; slot index advances; dump_count increments; -> IDLE.
REQ-025 Timeout counter zeroed on entry to WAIT_DONE.
REQ-026 pc_addr registered = cfg_base_addr + slot_idx * DUMP_BYTES, updated only in IDLE, held constant START through CLEAR.
REQ-027 Slot wrap: slot_idx == effective_num_slots-1 advances to 0; cfg_num_slots reduced below slot_idx wraps to 0 on next advance.
REQ-028 dump_req counted only when cfg_enable = 1; ignored otherwise without error.
REQ-029 dump_req with pending_cnt == MAX_PENDING and no same-cycle decrement: dropped, overflow_err set.
REQ-030 dump_req coincident with IDLE->START decrement: pending_cnt unchanged, no overflow.
REQ-031 cfg_enable deassert mid-dump: current dump completes; queued requests still serviced.
REQ-032 pc_done outside WAIT_DONE ignored.
REQ-033 err_clear clears both flags; same-cycle error set wins.
REQ-034 Minimum dump turnaround 4 cycles (IDLE, START, WAIT_DONE, CLEAR) with pc_done on first WAIT_DONE cycle.

Reset
REQ-035 On reset: state IDLE, pending_cnt 0, slot_idx 0, dump_count 0, pc_addr 0, pc_start 0, pc_clear 0, busy 0, both error flags 0.
REQ-036 Reset mid-dump aborts immediately; no pc_clear issued; late pc_done after reset ignored.

Structure
REQ-037 State enum and DUMP_BYTES default in shared package genesys_pc_pkg.
REQ-038 Single flat module; no sub-modules; instantiated beside performance_counters, driving its pc_start and axi_addr.

Verification
REQ-039 base 0x1000, slots 4, one dump_req, pc_done 10 cycles after pc_start -> pc_addr 0x1000, pc_clear one cycle after done, dump_count 1.
REQ-040 five dumps, slots 4 -> pc_addr sequence 0x1000, 0x1060, 0x10C0, 0x1120, 0x1000.
REQ-041 six dump_req on consecutive cycles while busy -> first starts, four queued, sixth dropped, overflow_err 1, five dumps complete.
REQ-042 no pc_done -> timeout_err after 4096 WAIT_DONE cycles, state IDLE, dump_count unchanged, no pc_clear.
REQ-043 reset asserted during WAIT_DONE, then pc_done -> all outputs at reset values, no pc_clear, pending_cnt 0.
REQ-044 cfg_enable 0 with dump_req -> no pc_start, pending_cnt 0, no error.

Source files
------------

// File: rtl/genesys_pc_pkg.sv
// rtl/genesys_pc_pkg.sv - shared types and defaults for the performance-counter dump path
package genesys_pc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_CLEAR     = 2'd3
    } pc_state_t;

    localparam int DUMP_BYTES_DEFAULT = 96;

endpackage

// File: rtl/pc_dump_scheduler.sv
// rtl/pc_dump_scheduler.sv - queues counter-dump requests and sequences start/done/clear
import genesys_pc_pkg::*;

module pc_dump_scheduler #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int DUMP_BYTES     = DUMP_BYTES_DEFAULT,
    parameter int MAX_PENDING    = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_enable,
    input  logic [AXI_ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [15:0]               cfg_num_slots,
    input  logic                      dump_req,
    input  logic                      err_clear,
    output logic                      pc_start,
    output logic [AXI_ADDR_WIDTH-1:0] pc_addr,
    input  logic                      pc_done,
    output logic                      pc_clear,
    output logic                      busy,
    output logic [2:0]                pending_cnt,
    output logic [31:0]               dump_count,
    output logic                      overflow_err,
    output logic                      timeout_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    pc_state_t                 state;
    logic [TW-1:0]             tmo_cnt;
    logic [15:0]               slot_idx;
    logic [15:0]               last_slot;
    logic [AXI_ADDR_WIDTH-1:0] slot_offset;
    logic                      take;
    logic                      req_ok;
    logic                      ovf_set;
    logic                      accept;
    logic                      tmo_set;

    // A slot count of zero behaves as a single-slot ring.
    assign last_slot   = (cfg_num_slots == 16'd0) ? 16'd0 : cfg_num_slots - 16'd1;
    assign slot_offset = AXI_ADDR_WIDTH'(slot_idx) * AXI_ADDR_WIDTH'(DUMP_BYTES);
    assign take        = (state == ST_IDLE) && (pending_cnt != 3'd0);
    assign req_ok      = dump_req && cfg_enable;
    assign ovf_set     = req_ok && !take && (pending_cnt == 3'(MAX_PENDING));
    assign accept      = req_ok && !ovf_set;
    assign tmo_set     = (state == ST_WAIT_DONE) && !pc_done &&
                         (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            tmo_cnt      <= '0;
            slot_idx     <= 16'd0;
            pc_start     <= 1'b0;
            pc_addr      <= '0;
            pc_clear     <= 1'b0;
            busy         <= 1'b0;
            pending_cnt  <= 3'd0;
            dump_count   <= 32'd0;
            overflow_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            pc_start    <= 1'b0;
            pc_clear    <= 1'b0;
            pending_cnt <= pending_cnt + 3'(accept) - 3'(take);

            // A new error in the same cycle as err_clear stays set.
            if (ovf_set)
                overflow_err <= 1'b1;
            else if (err_clear)
                overflow_err <= 1'b0;

            if (tmo_set)
                timeout_err <= 1'b1;
            else if (err_clear)
                timeout_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    pc_addr <= cfg_base_addr + slot_offset;
                    if (take) begin
                        state    <= ST_START;
                        pc_start <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ST_START: begin
                    state   <= ST_WAIT_DONE;
                    tmo_cnt <= '0;
                end
                ST_WAIT_DONE: begin
                    if (pc_done) begin
                        state    <= ST_CLEAR;
                        pc_clear <= 1'b1;
                    end else if (tmo_set) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ST_CLEAR: begin
                    // Ring shrunk below the current slot also wraps to zero.
                    slot_idx   <= (slot_idx >= last_slot) ? 16'd0 : slot_idx + 16'd1;
                    dump_count <= dump_count + 32'd1;
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_dump_scheduler.sv
// tb/tb_pc_dump_scheduler.sv - self-checking bench for pc_dump_scheduler
module tb_pc_dump_scheduler;

    localparam int TMO = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_enable = 1'b0;
    logic [63:0] cfg_base_addr = 64'h0;
    logic [15:0] cfg_num_slots = 16'd0;
    logic        dump_req = 1'b0;
    logic        err_clear = 1'b0;
    logic        man_done = 1'b0;
    logic        auto_done = 1'b0;
    logic        pc_done;
    logic        pc_start;
    logic [63:0] pc_addr;
    logic        pc_clear;
    logic        busy;
    logic [2:0]  pending_cnt;
    logic [31:0] dump_count;
    logic        overflow_err;
    logic        timeout_err;

    assign pc_done = man_done | auto_done;

    pc_dump_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_enable   (cfg_enable),
        .cfg_base_addr(cfg_base_addr),
        .cfg_num_slots(cfg_num_slots),
        .dump_req     (dump_req),
        .err_clear    (err_clear),
        .pc_start     (pc_start),
        .pc_addr      (pc_addr),
        .pc_done      (pc_done),
        .pc_clear     (pc_clear),
        .busy         (busy),
        .pending_cnt  (pending_cnt),
        .dump_count   (dump_count),
        .overflow_err (overflow_err),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    bit model_on = 1'b0;
    int auto_dly = 0;
    logic [63:0] addr_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: dump progress as a phase number plus a queue depth.
    int          m_phase = 0;
    int          m_q = 0;
    int          m_wait = 0;
    int          m_slot = 0;
    logic [31:0] m_count = 0;
    logic [63:0] m_addr = 0;
    bit          m_ovf = 0;
    bit          m_tmo = 0;

    always @(posedge clk) begin : model
        bit req, take, ovf_hit, tmo_hit;
        int eff;
        if (reset) begin
            m_phase = 0; m_q = 0; m_wait = 0; m_slot = 0;
            m_count = 0; m_addr = 0; m_ovf = 0; m_tmo = 0;
        end else begin
            req     = dump_req && cfg_enable;
            take    = (m_phase == 0) && (m_q > 0);
            ovf_hit = req && !take && (m_q == 4);
            tmo_hit = (m_phase == 2) && !pc_done && (m_wait == TMO - 1);
            eff     = (cfg_num_slots == 0) ? 1 : int'(cfg_num_slots);
            if (ovf_hit) m_ovf = 1; else if (err_clear) m_ovf = 0;
            if (tmo_hit) m_tmo = 1; else if (err_clear) m_tmo = 0;
            m_q = m_q + ((req && !ovf_hit) ? 1 : 0) - (take ? 1 : 0);
            case (m_phase)
                0: begin
                    m_addr = cfg_base_addr + 64'(m_slot * 96);
                    if (take) m_phase = 1;
                end
                1: begin m_phase = 2; m_wait = 0; end
                2: begin
                    if (pc_done) m_phase = 3;
                    else if (tmo_hit) m_phase = 0;
                    else m_wait++;
                end
                default: begin
                    m_slot  = (m_slot + 1 >= eff) ? 0 : m_slot + 1;
                    m_count = m_count + 1;
                    m_phase = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("pc_start",     64'(pc_start),     64'(m_phase == 1));
            chk("pc_clear",     64'(pc_clear),     64'(m_phase == 3));
            chk("busy",         64'(busy),         64'(m_phase != 0));
            chk("pending_cnt",  64'(pending_cnt),  64'(m_q));
            chk("dump_count",   64'(dump_count),   64'(m_count));
            chk("pc_addr",      pc_addr,           m_addr);
            chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
            chk("timeout_err",  64'(timeout_err),  64'(m_tmo));
        end
        if (pc_start) addr_q.push_back(pc_addr);
    end

    initial begin
        forever begin
            @(negedge clk);
            if (pc_start && auto_dly > 0) begin
                repeat (auto_dly) @(posedge clk);
                #1 auto_done = 1'b1;
                @(posedge clk);
                #1 auto_done = 1'b0;
            end
        end
    end

    task automatic pulse_req();
        @(posedge clk); #1 dump_req = 1'b1;
        @(posedge clk); #1 dump_req = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        int n = 0;
        repeat (3) @(negedge clk);
        while ((busy || pending_cnt != 3'd0) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= max_cycles) begin
            fails++;
            $display("FAIL %s idle wait expired actual=busy required=idle", name);
        end
    endtask

    initial begin
        int n;
        logic [63:0] exp_addr[12];
        exp_addr = '{64'h1000, 64'h1060, 64'h10C0, 64'h1120, 64'h1000,
                     64'h1060, 64'h10C0, 64'h1120, 64'h1000, 64'h1060,
                     64'h10C0, 64'h1000};

        repeat (2) @(posedge clk);
        model_on = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pc_addr", pc_addr, 64'd0);
        chk("rst_pending", 64'(pending_cnt), 64'd0);
        chk("rst_count", 64'(dump_count), 64'd0);

        @(posedge clk); #1;
        reset = 1'b0; cfg_enable = 1'b1;
        cfg_base_addr = 64'h1000; cfg_num_slots = 16'd4;

        // Single dump with pc_done ten cycles after pc_start.
        pulse_req();
        n = 0;
        while (!pc_start && n < 50) begin @(negedge clk); n++; end
        chk("first_start_seen", 64'(pc_start), 64'd1);
        repeat (10) @(posedge clk);
        #1 man_done = 1'b1;
        @(posedge clk); #1 man_done = 1'b0;
        @(negedge clk);
        chk("clear_after_done", 64'(pc_clear), 64'd1);
        @(negedge clk);
        chk("count_one", 64'(dump_count), 64'd1);
        chk("clear_one_cycle", 64'(pc_clear), 64'd0);

        // Four more single dumps walking the ring.
        auto_dly = 3;
        for (int i = 0; i < 4; i++) begin
            pulse_req();
            wait_idle(200, "ring_dump");
        end
        chk("count_five", 64'(dump_count), 64'd5);

        // Disabled requests are ignored.
        cfg_enable = 1'b0;
        pulse_req();
        repeat (10) @(negedge clk);
        chk("dis_pending", 64'(pending_cnt), 64'd0);
        chk("dis_ovf", 64'(overflow_err), 64'd0);
        chk("dis_count", 64'(dump_count), 64'd5);

        // Burst of six: one starts, four queue, the sixth overflows.
        cfg_enable = 1'b1;
        auto_dly = 2;
        @(posedge clk); #1 dump_req = 1'b1;
        repeat (6) @(posedge clk);
        #1 dump_req = 1'b0; cfg_enable = 1'b0;
        @(negedge clk);
        chk("burst_ovf", 64'(overflow_err), 64'd1);
        chk("burst_pending", 64'(pending_cnt), 64'd4);
        wait_idle(500, "burst");
        chk("burst_count", 64'(dump_count), 64'd10);
        cfg_enable = 1'b1;
        @(posedge clk); #1 err_clear = 1'b1;
        @(posedge clk); #1 err_clear = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", 64'(overflow_err), 64'd0);

        // Ring shrunk below the current slot: one dump there, then wrap to zero.
        cfg_num_slots = 16'd0;
        for (int i = 0; i < 2; i++) begin
            pulse_req();
            wait_idle(200, "shrink_dump");
        end
        chk("addr_count", 64'(addr_q.size()), 64'd12);
        for (int i = 0; i < 12; i++)
            if (i < addr_q.size()) chk($sformatf("addr_%0d", i), addr_q[i], exp_addr[i]);

        // pc_done while idle does nothing.
        auto_dly = 0;
        @(posedge clk); #1 man_done = 1'b1;
        @(posedge clk); #1 man_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_done_count", 64'(dump_count), 64'd12);

        // No pc_done: timeout after the full wait window.
        pulse_req();
        wait_idle(4300, "timeout");
        chk("tmo_flag", 64'(timeout_err), 64'd1);
        chk("tmo_count", 64'(dump_count), 64'd12);
        chk("tmo_busy", 64'(busy), 64'd0);

        // Reset while waiting for done, followed by a late pc_done.
        cfg_num_slots = 16'd4;
        pulse_req();
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", 64'(busy), 64'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; man_done = 1'b1;
        @(negedge clk);
        chk("rst2_busy", 64'(busy), 64'd0);
        chk("rst2_addr", pc_addr, 64'd0);
        chk("rst2_tmo", 64'(timeout_err), 64'd0);
        @(posedge clk); #1 man_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst2_count", 64'(dump_count), 64'd0);
        chk("rst2_pending", 64'(pending_cnt), 64'd0);
        chk("rst2_clear", 64'(pc_clear), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
